// File: rtl/pass_lock_ctrl.sv
// pass_lock_ctrl: sequencer for a 4-digit keypad password lock.
// It collects digits, checks them against the stored password on confirm,
// holds the unlock window, counts failed attempts, raises the lockout alarm
// and runs the password-change flow.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-low reset
//   i_key_valid    one-cycle pulse, i_key_code is valid
//   i_key_code     key value; 0..9 are digits, 10..15 are ignored
//   i_confirm      one-cycle pulse, submit the current entry
//   i_clear        one-cycle pulse, erase the current entry
//   i_set_mode     one-cycle pulse, request a password change (OPEN only)
//   o_entry_value  digits entered so far, right-aligned, newest in [3:0]
//   o_digit_cnt    number of digits entered (0..4)
//   o_state        IDLE=0 ENTRY=1 CHECK=2 OPEN=3 FAIL=4 LOCKOUT=5 SET_NEW=6
//   o_unlocked     high while in OPEN
//   o_alarm        high while in LOCKOUT
//   o_err          high for the single FAIL cycle
//   o_pw_updated   one-cycle pulse after a new password is stored
//   o_fail_cnt     consecutive mismatches
module pass_lock_ctrl #(
  parameter int unsigned MAX_FAIL      = 3,
  parameter int unsigned UNLOCK_CYCLES = 500,
  parameter int unsigned LOCK_CYCLES   = 1000,
  parameter logic [15:0] DEFAULT_PW    = 16'h1234
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_key_valid,
  input  logic [3:0]  i_key_code,
  input  logic        i_confirm,
  input  logic        i_clear,
  input  logic        i_set_mode,
  output logic [15:0] o_entry_value,
  output logic [2:0]  o_digit_cnt,
  output logic [2:0]  o_state,
  output logic        o_unlocked,
  output logic        o_alarm,
  output logic        o_err,
  output logic        o_pw_updated,
  output logic [2:0]  o_fail_cnt
);

  localparam int unsigned TMAX = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_OPEN    = 3'd3,
    S_FAIL    = 3'd4,
    S_LOCKOUT = 3'd5,
    S_SET_NEW = 3'd6
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_entry, w_entry_nxt;
  logic [2:0]    r_cnt, w_cnt_nxt;
  logic [TW-1:0] r_timer, w_timer_nxt;
  logic [2:0]    r_fail, w_fail_nxt;
  logic [15:0]   r_pw, w_pw_nxt;
  logic          r_pw_upd, w_pw_upd_nxt;

  logic          w_capture_st;
  logic          w_digit_ok;
  logic          w_full_confirm;
  logic [3:0]    w_fail_inc;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_entry  <= 16'h0000;
      r_cnt    <= 3'd0;
      r_timer  <= '0;
      r_fail   <= 3'd0;
      r_pw     <= DEFAULT_PW;
      r_pw_upd <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_entry  <= w_entry_nxt;
      r_cnt    <= w_cnt_nxt;
      r_timer  <= w_timer_nxt;
      r_fail   <= w_fail_nxt;
      r_pw     <= w_pw_nxt;
      r_pw_upd <= w_pw_upd_nxt;
    end
  end

  // Next-state and datapath updates
  always_comb begin
    w_state_nxt  = r_state;
    w_entry_nxt  = r_entry;
    w_cnt_nxt    = r_cnt;
    w_timer_nxt  = r_timer;
    w_fail_nxt   = r_fail;
    w_pw_nxt     = r_pw;
    w_pw_upd_nxt = 1'b0;

    w_capture_st   = (r_state == S_IDLE) || (r_state == S_ENTRY) || (r_state == S_SET_NEW);
    // clear and confirm both outrank a key in the same cycle
    w_digit_ok     = i_key_valid && (i_key_code <= 4'd9) && (r_cnt < 3'd4) && !i_clear && !i_confirm;
    w_full_confirm = i_confirm && !i_clear && (r_cnt == 3'd4);
    w_fail_inc     = 4'(r_fail) + 4'd1;

    if (w_capture_st) begin
      if (i_clear) begin
        w_entry_nxt = 16'h0000;
        w_cnt_nxt   = 3'd0;
        if (r_state == S_ENTRY) w_state_nxt = S_IDLE;
      end else if (w_digit_ok) begin
        w_entry_nxt = {r_entry[11:0], i_key_code};
        w_cnt_nxt   = r_cnt + 3'd1;
        if (r_state == S_IDLE) w_state_nxt = S_ENTRY;
      end
    end

    case (r_state)
      S_IDLE: ;
      S_ENTRY: begin
        if (w_full_confirm) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        w_entry_nxt = 16'h0000;
        w_cnt_nxt   = 3'd0;
        if (r_entry == r_pw) begin
          w_state_nxt = S_OPEN;
          w_fail_nxt  = 3'd0;
          w_timer_nxt = TW'(UNLOCK_CYCLES - 1);
        end else begin
          w_fail_nxt = r_fail + 3'd1;
          if (w_fail_inc >= 4'(MAX_FAIL)) begin
            w_state_nxt = S_LOCKOUT;
            w_timer_nxt = TW'(LOCK_CYCLES - 1);
          end else begin
            w_state_nxt = S_FAIL;
          end
        end
      end
      S_FAIL: w_state_nxt = S_IDLE;
      S_OPEN: begin
        // set_mode wins over window expiry
        if (i_set_mode) begin
          w_state_nxt = S_SET_NEW;
          w_timer_nxt = '0;
        end else if (r_timer == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
      S_SET_NEW: begin
        if (w_full_confirm) begin
          w_pw_nxt     = r_entry;
          w_pw_upd_nxt = 1'b1;
          w_entry_nxt  = 16'h0000;
          w_cnt_nxt    = 3'd0;
          w_state_nxt  = S_IDLE;
        end
      end
      S_LOCKOUT: begin
        if (r_timer == '0) begin
          w_fail_nxt  = 3'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_entry_value = r_entry;
  assign o_digit_cnt   = r_cnt;
  assign o_state       = r_state;
  assign o_unlocked    = (r_state == S_OPEN);
  assign o_alarm       = (r_state == S_LOCKOUT);
  assign o_err         = (r_state == S_FAIL);
  assign o_pw_updated  = r_pw_upd;
  assign o_fail_cnt    = r_fail;

endmodule

// File: tb/tb_pass_lock_ctrl.sv
// Scoreboard bench for pass_lock_ctrl: the driver steps a behavioural lock
// model each cycle and queues the expected outputs; the monitor pops and
// compares after every active edge.
module tb_pass_lock_ctrl;

  localparam int unsigned MAX_FAIL      = 3;
  localparam int unsigned UNLOCK_CYCLES = 500;
  localparam int unsigned LOCK_CYCLES   = 1000;
  localparam logic [15:0] DEFAULT_PW    = 16'h1234;

  localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_OPEN = 3,
                 M_FAIL = 4, M_LOCKOUT = 5, M_SET_NEW = 6;

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] ev;
    logic [2:0]  cnt;
    logic        unl;
    logic        alm;
    logic        err;
    logic        upd;
    logic [2:0]  fc;
  } snap_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid, confirm, clear, set_mode;
  logic [3:0]  key_code;
  logic [15:0] entry_value;
  logic [2:0]  digit_cnt, state, fail_cnt;
  logic        unlocked, alarm, err, pw_updated;

  int checks = 0;
  int errors = 0;
  snap_t exp_q[$];

  // behavioural model state
  int          m_state;
  int          m_digits[$];
  int          m_rem;
  int          m_fail;
  logic [15:0] m_pw;
  bit          m_upd;

  pass_lock_ctrl #(
    .MAX_FAIL(MAX_FAIL), .UNLOCK_CYCLES(UNLOCK_CYCLES),
    .LOCK_CYCLES(LOCK_CYCLES), .DEFAULT_PW(DEFAULT_PW)
  ) dut (
    .clk(clk), .rst(rst),
    .i_key_valid(key_valid), .i_key_code(key_code), .i_confirm(confirm),
    .i_clear(clear), .i_set_mode(set_mode),
    .o_entry_value(entry_value), .o_digit_cnt(digit_cnt), .o_state(state),
    .o_unlocked(unlocked), .o_alarm(alarm), .o_err(err),
    .o_pw_updated(pw_updated), .o_fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 16 + m_digits[i];
    return 16'(v);
  endfunction

  function automatic snap_t m_snap();
    snap_t s;
    s.st  = 3'(m_state);
    s.ev  = m_value();
    s.cnt = 3'(m_digits.size());
    s.unl = (m_state == M_OPEN);
    s.alm = (m_state == M_LOCKOUT);
    s.err = (m_state == M_FAIL);
    s.upd = m_upd;
    s.fc  = 3'(m_fail);
    return s;
  endfunction

  function automatic snap_t dut_snap();
    snap_t s;
    s.st = state; s.ev = entry_value; s.cnt = digit_cnt; s.unl = unlocked;
    s.alm = alarm; s.err = err; s.upd = pw_updated; s.fc = fail_cnt;
    return s;
  endfunction

  task automatic m_reset();
    m_state = M_IDLE;
    m_digits.delete();
    m_rem  = 0;
    m_fail = 0;
    m_pw   = DEFAULT_PW;
    m_upd  = 0;
  endtask

  // One clock of the lock's rules, written over a digit list and a countdown
  task automatic m_step(input bit kv, input int kc, input bit cf, input bit cl, input bit sm);
    int ns = m_state;
    bit upd = 0;
    case (m_state)
      M_IDLE, M_ENTRY, M_SET_NEW: begin
        if (cl) begin
          m_digits.delete();
          if (m_state == M_ENTRY) ns = M_IDLE;
        end else if (cf) begin
          if (m_digits.size() == 4) begin
            if (m_state == M_ENTRY) ns = M_CHECK;
            if (m_state == M_SET_NEW) begin
              m_pw = m_value();
              upd  = 1;
              m_digits.delete();
              ns   = M_IDLE;
            end
          end
        end else if (kv && kc < 10 && m_digits.size() < 4) begin
          m_digits.push_back(kc);
          if (m_state == M_IDLE) ns = M_ENTRY;
        end
      end
      M_CHECK: begin
        if (m_value() == m_pw) begin
          ns = M_OPEN; m_fail = 0; m_rem = UNLOCK_CYCLES - 1;
        end else begin
          m_fail++;
          if (m_fail >= MAX_FAIL) begin
            ns = M_LOCKOUT; m_rem = LOCK_CYCLES - 1;
          end else ns = M_FAIL;
        end
        m_digits.delete();
      end
      M_FAIL: ns = M_IDLE;
      M_OPEN: begin
        if (sm) begin ns = M_SET_NEW; m_rem = 0; end
        else if (m_rem == 0) ns = M_IDLE;
        else m_rem--;
      end
      M_LOCKOUT: begin
        if (m_rem == 0) begin ns = M_IDLE; m_fail = 0; end
        else m_rem--;
      end
      default: ns = M_IDLE;
    endcase
    m_state = ns;
    m_upd   = upd;
  endtask

  task automatic compare(input string name, input snap_t got, input snap_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s t=%0t got st=%0d ev=%h cnt=%0d unl=%b alm=%b err=%b upd=%b fc=%0d want st=%0d ev=%h cnt=%0d unl=%b alm=%b err=%b upd=%b fc=%0d",
               name, $time, got.st, got.ev, got.cnt, got.unl, got.alm, got.err, got.upd, got.fc,
               want.st, want.ev, want.cnt, want.unl, want.alm, want.err, want.upd, want.fc);
    end
  endtask

  // Drive one cycle of inputs and queue what the lock must show after the edge
  task automatic cyc(input bit kv, input int kc, input bit cf, input bit cl, input bit sm);
    @(negedge clk);
    key_valid = kv; key_code = 4'(kc); confirm = cf; clear = cl; set_mode = sm;
    m_step(kv, kc, cf, cl, sm);
    exp_q.push_back(m_snap());
  endtask

  task automatic key(input int d);     cyc(1, d, 0, 0, 0); endtask
  task automatic idle(input int n);    repeat (n) cyc(0, 0, 0, 0, 0); endtask
  task automatic do_confirm();         cyc(0, 0, 1, 0, 0); endtask

  task automatic enter_pw(input logic [15:0] pw);
    for (int i = 0; i < 4; i++) key(int'(pw[15 - 4 * i -: 4]));
    do_confirm();
  endtask

  task automatic apply_reset(input string name);
    @(negedge clk);
    key_valid = 0; confirm = 0; clear = 0; set_mode = 0; key_code = 0;
    rst = 1'b0;
    m_reset();
    #1 compare(name, dut_snap(), m_snap());
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: compare every queued expectation right after the active edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) compare("cycle", dut_snap(), exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b0;
    key_valid = 0; key_code = 0; confirm = 0; clear = 0; set_mode = 0;
    m_reset();
    #2 compare("reset_state", dut_snap(), m_snap());
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // correct entry and the full unlock window
    enter_pw(16'h1234);
    idle(UNLOCK_CYCLES + 5);

    // three mismatches into lockout, keys ignored during lockout
    for (int a = 0; a < 3; a++) begin
      enter_pw(16'h5555);
      idle(3);
    end
    enter_pw(16'h1234);
    idle(LOCK_CYCLES);

    // entry edge cases
    key(9); key(8); do_confirm();
    key(7); key(6); key(5); key(12);
    cyc(0, 0, 0, 1, 0);
    idle(2);

    // same-cycle priority
    key(1);
    cyc(1, 3, 0, 1, 0);
    key(1); key(2); key(3); key(4);
    cyc(1, 5, 1, 0, 0);
    idle(UNLOCK_CYCLES + 3);

    // password change, then reset restores the default
    enter_pw(16'h1234);
    idle(3);
    cyc(0, 0, 0, 0, 1);
    enter_pw(16'h4321);
    idle(2);
    enter_pw(16'h1234);
    idle(3);
    enter_pw(16'h4321);
    idle(4);
    apply_reset("reset_in_open");
    enter_pw(16'h1234);
    idle(4);
    apply_reset("reset_in_open2");

    // reset in the middle of lockout
    for (int a = 0; a < 3; a++) begin
      enter_pw(16'h9999);
      idle(2);
    end
    idle(498);
    apply_reset("reset_in_lockout");
    idle(3);

    // randomized traffic, with occasional correct entries to reach OPEN/SET_NEW
    for (int n = 0; n < 4000; n++) begin
      int r;
      if (m_state == M_IDLE && $urandom_range(0, 59) == 0) begin
        enter_pw(m_pw);
      end else begin
        r = int'($urandom_range(0, 99));
        cyc(r < 25, int'($urandom_range(0, 15)),
            $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 3,
            $urandom_range(0, 99) < 4);
      end
    end
    idle(2);

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pass_lock_ctrl.md
Name: pass_lock_ctrl

Overview:
Top-level sequencer for the 4-digit keypad password lock. Collects digits from the key decoder, drives the entry display value, and compares against the stored password on confirm. Manages the unlock window, failed-attempt counting, lockout alarm and the password-change flow. All logic is synchronous to clk; key inputs arrive as single-cycle pulses already synchronised to clk.

Parameters:
MAX_FAIL, 3, consecutive mismatches that trigger LOCKOUT (1..7)
UNLOCK_CYCLES, 500, clk cycles the OPEN state is held
LOCK_CYCLES, 1000, clk cycles the LOCKOUT state is held
DEFAULT_PW, 16'h1234, stored password after reset (4 BCD nibbles, first digit in [15:12])

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
key_valid  in  1  one-cycle pulse: key_code is valid
key_code  in  4  key value; only 0..9 are digits, 10..15 ignored
confirm  in  1  one-cycle pulse: submit entry
clear  in  1  one-cycle pulse: erase current entry
set_mode  in  1  one-cycle pulse: request password change (honoured only in OPEN)
entry_value  out  16  digits entered so far, right-aligned, newest digit in [3:0]
digit_cnt  out  3  number of digits entered (0..4)
state  out  3  IDLE=0, ENTRY=1, CHECK=2, OPEN=3, FAIL=4, LOCKOUT=5, SET_NEW=6
unlocked  out  1  high while in OPEN
alarm  out  1  high while in LOCKOUT
err  out  1  one-cycle pulse in FAIL
pw_updated  out  1  one-cycle pulse when a new password is stored
fail_cnt  out  3  consecutive mismatches

Behaviour:
- Reset (async, rst=0): state=IDLE; entry_value=0; digit_cnt=0; fail_cnt=0; stored_pw=DEFAULT_PW; timer=0; unlocked, alarm, err and pw_updated all 0.
- Digit capture (IDLE, ENTRY, SET_NEW only):
  - A key_valid with key_code<=9 and digit_cnt<4 sets entry_value <= {entry_value[11:0], key_code} and increments digit_cnt.
  - A fifth digit is ignored, with no wrap. Codes 10..15 are ignored.
- Priority within one cycle: clear > confirm > key_valid. clear zeroes entry_value and digit_cnt; state is unchanged, except ENTRY returns to IDLE.
- IDLE: the first accepted digit moves to ENTRY.
- ENTRY: confirm with digit_cnt==4 moves to CHECK. Confirm with digit_cnt<4 is ignored.
- CHECK (exactly 1 cycle): compare entry_value with stored_pw. entry_value and digit_cnt clear on exit.
  - Match: next state OPEN, fail_cnt <= 0, timer loads UNLOCK_CYCLES-1.
  - Mismatch: fail_cnt+1. If the new count is >= MAX_FAIL, go to LOCKOUT and load the timer with LOCK_CYCLES-1. Otherwise go to FAIL.
- FAIL (1 cycle): err=1, then IDLE.
- OPEN: unlocked=1 and the timer decrements each cycle.
  - set_mode moves to SET_NEW and clears the timer; set_mode has priority over expiry in the same cycle.
  - Otherwise timer==0 moves to IDLE.
  - Digits and confirm are ignored in OPEN.
- SET_NEW: digits are captured as in ENTRY.
  - confirm with digit_cnt==4: stored_pw <= entry_value, pw_updated=1 for that cycle, entry cleared, go to IDLE.
  - confirm with digit_cnt<4 is ignored. There is no timeout.
- LOCKOUT: alarm=1; all inputs are ignored; the timer decrements. At timer==0: fail_cnt <= 0, go to IDLE.
- set_mode is ignored outside OPEN.
- Outputs are registered; unlocked and alarm are decoded from the registered state.
- The timer is sized for max(UNLOCK_CYCLES, LOCK_CYCLES).
- Reset asserted mid-operation aborts any state. A password changed in SET_NEW reverts to DEFAULT_PW (no non-volatile store).
- Unused state encoding 7 recovers to IDLE on the next clock.

Test Plan:
- Correct entry: after reset, keys 1,2,3,4 then confirm → CHECK for 1 cycle, then OPEN with unlocked=1 for exactly 500 cycles, then IDLE; fail_cnt=0.
- Lockout: enter 5,5,5,5 + confirm three times → err pulses twice and fail_cnt goes 1, 2. On the third attempt, LOCKOUT with alarm=1 for 1000 cycles; keys 1,2,3,4 entered during LOCKOUT are ignored. Exit to IDLE with fail_cnt=0.
- Entry edge cases: keys 9,8 + confirm → ignored, stays ENTRY with entry_value=16'h0098. Keys 7,6,5 → entry_value=16'h9876 (the 5 is ignored), digit_cnt=4. Key_code 12 → ignored. Clear → entry_value=0, state IDLE.
- Same-cycle priority: clear and key_valid(3) in one cycle → entry_value=0. Confirm and key_valid in one cycle with digit_cnt=4 → CHECK, digit not shifted.
- Password change: unlock with 1234, set_mode → SET_NEW. Keys 4,3,2,1 + confirm → pw_updated pulse, IDLE. Then 1234 fails (err) and 4321 opens. Reset → 1234 opens again.
- Reset mid-LOCKOUT: assert rst at timer≈500 → immediately IDLE with alarm=0 and fail_cnt=0.
